// File: rtl/iso_sched_pkg.sv
// rtl/iso_sched_pkg.sv - shared types and constants for the isochronous TU scheduler
package iso_sched_pkg;

  localparam int TU_SIZE_C = 64;
  localparam int FRAC_W_C  = 10;
  localparam int VC_MIN    = 1;
  localparam int VC_MAX    = TU_SIZE_C - 2;

  typedef enum logic [2:0] {
    SYM_NONE = 3'd0,
    SYM_DATA = 3'd1,
    SYM_FS   = 3'd2,
    SYM_FILL = 3'd3,
    SYM_FE   = 3'd4
  } sym_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_e;

  // vc is always clamped below last_slot, so FS and FE never collide
  function automatic sym_type_e slot_sym(input logic [5:0] slot,
                                         input logic [5:0] vc,
                                         input logic [5:0] last_slot);
    if (slot < vc)
      return SYM_DATA;
    else if (slot == vc)
      return SYM_FS;
    else if (slot == last_slot)
      return SYM_FE;
    else
      return SYM_FILL;
  endfunction

endpackage

// File: rtl/iso_tu_frac_acc.sv
// rtl/iso_tu_frac_acc.sv - fractional valid-symbol accumulator with clamp, yields vc per TU
module iso_tu_frac_acc
  import iso_sched_pkg::*;
#(
  parameter int TU_SIZE = TU_SIZE_C,
  parameter int FRAC_W  = FRAC_W_C
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              step,
  input  logic [5:0]        vs_int,
  input  logic [FRAC_W-1:0] vs_frac,
  output logic [5:0]        vc
);

  localparam int VC_HI = TU_SIZE - 2;

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;
  logic [6:0]        vc_raw;

  // init treats the accumulator as already cleared so the first TU of a line starts from zero
  always_comb begin
    sum    = {1'b0, (init ? '0 : acc)} + {1'b0, vs_frac};
    vc_raw = {1'b0, vs_int} + 7'(sum[FRAC_W]);
    if (vc_raw < 7'(VC_MIN))
      vc = 6'(VC_MIN);
    else if (vc_raw > 7'(VC_HI))
      vc = 6'(VC_HI);
    else
      vc = vc_raw[5:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      acc <= '0;
    else if (init || step)
      acc <= sum[FRAC_W-1:0];
  end

endmodule

// File: rtl/iso_tu_scheduler.sv
// rtl/iso_tu_scheduler.sv - per-line TU sequencer choosing DATA/FS/FILL/FE per lane clock
module iso_tu_scheduler
  import iso_sched_pkg::*;
#(
  parameter int TU_SIZE = TU_SIZE_C,
  parameter int FRAC_W  = FRAC_W_C,
  parameter int LCNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_vld,
  input  logic [5:0]        cfg_vs_int,
  input  logic [FRAC_W-1:0] cfg_vs_frac,
  input  logic [LCNT_W-1:0] cfg_line_syms,
  input  logic              line_start,
  input  logic              fifo_empty,
  output logic [2:0]        sym_type,
  output logic [5:0]        tu_slot,
  output logic              busy,
  output logic              line_done,
  output logic              underflow
);

  localparam logic [5:0] LAST_SLOT = 6'(TU_SIZE - 1);

  sched_state_e      state;
  logic [5:0]        sh_int;
  logic [FRAC_W-1:0] sh_frac;
  logic [LCNT_W-1:0] sh_syms;
  logic [5:0]        act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [LCNT_W-1:0] rem;
  logic [5:0]        vc_q;

  logic              acc_init;
  logic              tu_wrap;
  logic [5:0]        acc_int;
  logic [FRAC_W-1:0] acc_frac;
  logic [5:0]        acc_vc;
  logic [5:0]        next_slot;
  logic [5:0]        vc_eff;
  sym_type_e         next_sym;

  always_comb begin
    acc_init  = (state == ST_IDLE) && line_start && (sh_syms != '0);
    tu_wrap   = (state == ST_RUN) && (rem != '0) && (tu_slot == LAST_SLOT);
    acc_int   = acc_init ? sh_int  : act_int;
    acc_frac  = acc_init ? sh_frac : act_frac;
    next_slot = (tu_slot == LAST_SLOT) ? 6'd0 : tu_slot + 6'd1;
    vc_eff    = tu_wrap ? acc_vc : vc_q;
    next_sym  = slot_sym(next_slot, vc_eff, LAST_SLOT);
  end

  iso_tu_frac_acc #(
    .TU_SIZE (TU_SIZE),
    .FRAC_W  (FRAC_W)
  ) u_frac_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (acc_init),
    .step    (tu_wrap),
    .vs_int  (acc_int),
    .vs_frac (acc_frac),
    .vc      (acc_vc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sh_int    <= '0;
      sh_frac   <= '0;
      sh_syms   <= '0;
      act_int   <= '0;
      act_frac  <= '0;
      rem       <= '0;
      vc_q      <= '0;
      sym_type  <= SYM_NONE;
      tu_slot   <= '0;
      busy      <= 1'b0;
      line_done <= 1'b0;
      underflow <= 1'b0;
    end else begin
      line_done <= 1'b0;
      if (cfg_vld) begin
        sh_int    <= cfg_vs_int;
        sh_frac   <= cfg_vs_frac;
        sh_syms   <= cfg_line_syms;
        underflow <= 1'b0;
      end
      // later assignment lets an underflow event override a same-cycle clear
      if ((sym_type == SYM_DATA) && fifo_empty)
        underflow <= 1'b1;

      case (state)
        ST_IDLE: begin
          sym_type <= SYM_NONE;
          tu_slot  <= '0;
          busy     <= 1'b0;
          if (line_start) begin
            act_int  <= sh_int;
            act_frac <= sh_frac;
            if (sh_syms == '0) begin
              line_done <= 1'b1;
            end else begin
              state    <= ST_RUN;
              busy     <= 1'b1;
              vc_q     <= acc_vc;
              sym_type <= SYM_DATA;
              rem      <= sh_syms - LCNT_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (rem == '0) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            line_done <= 1'b1;
            sym_type  <= SYM_NONE;
            tu_slot   <= '0;
          end else begin
            tu_slot  <= next_slot;
            sym_type <= next_sym;
            if (tu_wrap)
              vc_q <= acc_vc;
            if (next_sym == SYM_DATA)
              rem <= rem - LCNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iso_tu_scheduler.sv
// tb/tb_iso_tu_scheduler.sv - directed self-checking bench for iso_tu_scheduler
module tb_iso_tu_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_vld;
  logic [5:0]  cfg_vs_int;
  logic [9:0]  cfg_vs_frac;
  logic [15:0] cfg_line_syms;
  logic        line_start;
  logic        fifo_empty;
  logic [2:0]  sym_type;
  logic [5:0]  tu_slot;
  logic        busy;
  logic        line_done;
  logic        underflow;

  int vectors = 0;
  int miscompares = 0;
  int exp_uf = 0;

  always #5 clk = ~clk;

  iso_tu_scheduler #(
    .TU_SIZE (64),
    .FRAC_W  (10),
    .LCNT_W  (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_vld       (cfg_vld),
    .cfg_vs_int    (cfg_vs_int),
    .cfg_vs_frac   (cfg_vs_frac),
    .cfg_line_syms (cfg_line_syms),
    .line_start    (line_start),
    .fifo_empty    (fifo_empty),
    .sym_type      (sym_type),
    .tu_slot       (tu_slot),
    .busy          (busy),
    .line_done     (line_done),
    .underflow     (underflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cfg_load(input int vi, input int vf, input int syms);
    cfg_vld       = 1'b1;
    cfg_vs_int    = 6'(vi);
    cfg_vs_frac   = 10'(vf);
    cfg_line_syms = 16'(syms);
    step();
    cfg_vld = 1'b0;
    exp_uf  = 0;
  endtask

  // Pulses line_start, then checks every cycle of the line; vc_a/vc_b are the expected
  // valid counts for even/odd TUs. Optional mid-line events are keyed by cycle index.
  task automatic run_line(input string name, input int syms, input int vc_a, input int vc_b,
                          input int ls_cyc, input int cfg_cyc, input int new_int,
                          input int new_syms, input int empty_cyc);
    int slot, tu, sent, cyc, vc, exp;
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    slot = 0; tu = 0; sent = 0; cyc = 0;
    while (sent < syms) begin
      vc  = (tu % 2 == 0) ? vc_a : vc_b;
      exp = (slot < vc) ? 1 : (slot == vc) ? 2 : (slot == 63) ? 4 : 3;
      check($sformatf("%s sym c%0d", name, cyc), sym_type, exp);
      check($sformatf("%s slot c%0d", name, cyc), tu_slot, slot);
      check($sformatf("%s busy c%0d", name, cyc), busy, 1);
      check($sformatf("%s done c%0d", name, cyc), line_done, 0);
      check($sformatf("%s uf c%0d", name, cyc), underflow, exp_uf);
      if (exp == 1) sent++;
      if (cyc == ls_cyc) line_start = 1'b1;
      if (cyc == cfg_cyc) begin
        cfg_vld       = 1'b1;
        cfg_vs_int    = 6'(new_int);
        cfg_line_syms = 16'(new_syms);
      end
      if (cyc == empty_cyc) fifo_empty = 1'b1;
      step();
      if (cyc == cfg_cyc) exp_uf = 0;
      if (cyc == empty_cyc && exp == 1) exp_uf = 1;
      line_start = 1'b0;
      cfg_vld    = 1'b0;
      fifo_empty = 1'b0;
      slot = (slot == 63) ? 0 : slot + 1;
      if (slot == 0) tu++;
      cyc++;
    end
    check($sformatf("%s end sym", name), sym_type, 0);
    check($sformatf("%s end done", name), line_done, 1);
    check($sformatf("%s end busy", name), busy, 0);
    check($sformatf("%s end uf", name), underflow, exp_uf);
    step();
    check($sformatf("%s post done", name), line_done, 0);
    check($sformatf("%s post busy", name), busy, 0);
    check($sformatf("%s post sym", name), sym_type, 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    cfg_vld       = 1'b0;
    cfg_vs_int    = '0;
    cfg_vs_frac   = '0;
    cfg_line_syms = '0;
    line_start    = 1'b0;
    fifo_empty    = 1'b0;
    step();
    step();
    check("rst sym", sym_type, 0);
    check("rst slot", tu_slot, 0);
    check("rst busy", busy, 0);
    check("rst done", line_done, 0);
    check("rst uf", underflow, 0);
    rst_n = 1'b1;
    step();

    cfg_load(40, 0, 100);
    run_line("int40", 100, 40, 40, -1, -1, 0, 0, -1);

    cfg_load(40, 512, 200);
    run_line("frac512", 200, 40, 41, -1, -1, 0, 0, -1);

    cfg_load(63, 1023, 70);
    run_line("clamp_hi", 70, 62, 62, -1, -1, 0, 0, -1);

    cfg_load(0, 0, 3);
    run_line("clamp_lo", 3, 1, 1, -1, -1, 0, 0, -1);

    cfg_load(40, 0, 0);
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    check("zero done", line_done, 1);
    check("zero busy", busy, 0);
    check("zero sym", sym_type, 0);
    step();
    check("zero post done", line_done, 0);
    check("zero post busy", busy, 0);
    check("zero post sym", sym_type, 0);

    cfg_load(40, 0, 50);
    run_line("mid", 50, 40, 40, 10, 20, 20, 30, 5);
    run_line("next", 30, 20, 20, -1, 3, 20, 30, 3);

    cfg_load(40, 0, 100);
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    step();
    fifo_empty = 1'b1;
    step();
    fifo_empty = 1'b0;
    step();
    check("pre_rst uf", underflow, 1);
    check("pre_rst busy", busy, 1);
    check("pre_rst slot", tu_slot, 3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst sym", sym_type, 0);
    check("midrst slot", tu_slot, 0);
    check("midrst busy", busy, 0);
    check("midrst done", line_done, 0);
    check("midrst uf", underflow, 0);
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    check("shadow_rst done", line_done, 1);
    check("shadow_rst busy", busy, 0);
    check("shadow_rst sym", sym_type, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
